// File: rtl/pulse_timing_meter.sv
// Measures high time, low time and period of an asynchronous waveform in clk cycles,
// publishing one result per full period and flagging a waveform stuck high or low.
module pulse_timing_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sig_in_i,
  output logic [CNT_W-1:0] ton_cyc_o,
  output logic [CNT_W-1:0] toff_cyc_o,
  output logic [CNT_W:0]   period_cyc_o,
  output logic             meas_valid_o,
  output logic             stuck_high_o,
  output logic             stuck_low_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [CNT_W-1:0]       hcnt_q, hcnt_d;
  logic [CNT_W-1:0]       lcnt_q, lcnt_d;
  logic [CNT_W-1:0]       ton_q, ton_d;
  logic [CNT_W-1:0]       toff_q, toff_d;
  logic [CNT_W:0]         period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   stuck_high_q, stuck_high_d;
  logic                   stuck_low_q, stuck_low_d;

  logic sig_s, rise, fall;

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~s_d_q;
  assign fall  = ~sig_s & s_d_q;

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    lcnt_d       = lcnt_q;
    ton_d        = ton_q;
    toff_d       = toff_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;

    if (!en_i) begin
      // Disabling drops any partial period; results and stuck flags are kept.
      state_d = StIdle;
      hcnt_d  = '0;
      lcnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            hcnt_d       = {{(CNT_W-1){1'b0}}, 1'b1};
            state_d      = StHigh;
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
          end
        end
        StHigh: begin
          if (fall) begin
            lcnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = StLow;
          end else if (hcnt_q == CntMax) begin
            stuck_high_d = 1'b1;
            state_d      = StIdle;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        StLow: begin
          if (rise) begin
            ton_d    = hcnt_q;
            toff_d   = lcnt_q;
            period_d = {1'b0, hcnt_q} + {1'b0, lcnt_q};
            valid_d  = 1'b1;
            hcnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            state_d  = StHigh;
          end else if (lcnt_q == CntMax) begin
            stuck_low_d = 1'b1;
            state_d     = StIdle;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      sync_q       <= '0;
      s_d_q        <= 1'b0;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      ton_q        <= '0;
      toff_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      // Synchroniser and edge history run regardless of en_i.
      sync_q       <= {sync_q[SYNC_STAGES-2:0], sig_in_i};
      s_d_q        <= sig_s;
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      ton_q        <= ton_d;
      toff_q       <= toff_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign ton_cyc_o    = ton_q;
  assign toff_cyc_o   = toff_q;
  assign period_cyc_o = period_q;
  assign meas_valid_o = valid_q;
  assign stuck_high_o = stuck_high_q;
  assign stuck_low_o  = stuck_low_q;

endmodule

// File: tb/tb_pulse_timing_meter.sv
// Bench for pulse_timing_meter: directed waveforms then random pulse trains, checked every cycle
// against a timestamp-based model of rises and falls.
module tb_pulse_timing_meter;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          MAXV        = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             sig;
  logic [CNT_W-1:0] ton_cyc;
  logic [CNT_W-1:0] toff_cyc;
  logic [CNT_W:0]   period_cyc;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;

  pulse_timing_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .sig_in_i    (sig),
    .ton_cyc_o   (ton_cyc),
    .toff_cyc_o  (toff_cyc),
    .period_cyc_o(period_cyc),
    .meas_valid_o(meas_valid),
    .stuck_high_o(stuck_high),
    .stuck_low_o (stuck_low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: sample history plus timestamps of the accepted rise and following fall.
  logic hist [SYNC_STAGES+1];
  int   edge_n = 0;
  int   r_t    = -1;
  int   f_t    = -1;
  int   exp_ton = 0, exp_toff = 0, exp_per = 0;
  logic exp_mv = 1'b0, exp_sh = 1'b0, exp_sl = 1'b0;

  task automatic model_edge(input logic r, input logic e, input logic x);
    logic s, sd, rise, fall;
    s    = hist[SYNC_STAGES-1];
    sd   = hist[SYNC_STAGES];
    rise = s & ~sd;
    fall = ~s & sd;
    exp_mv = 1'b0;
    if (!r) begin
      exp_ton = 0; exp_toff = 0; exp_per = 0;
      exp_sh = 1'b0; exp_sl = 1'b0;
      r_t = -1; f_t = -1;
      for (int i = 0; i <= SYNC_STAGES; i++) hist[i] = 1'b0;
    end else begin
      if (!e) begin
        r_t = -1; f_t = -1;
      end else if (rise) begin
        if (r_t >= 0 && f_t >= 0) begin
          exp_ton  = f_t - r_t;
          exp_toff = edge_n - f_t;
          exp_per  = exp_ton + exp_toff;
          exp_mv   = 1'b1;
        end
        exp_sh = 1'b0; exp_sl = 1'b0;
        r_t = edge_n; f_t = -1;
      end else if (fall && r_t >= 0 && f_t < 0) begin
        f_t = edge_n;
      end else if (r_t >= 0 && f_t < 0 && edge_n - r_t == MAXV) begin
        exp_sh = 1'b1; r_t = -1;
      end else if (f_t >= 0 && edge_n - f_t == MAXV) begin
        exp_sl = 1'b1; r_t = -1; f_t = -1;
      end
      for (int i = SYNC_STAGES; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = x;
    end
    edge_n++;
  endtask

  // Apply inputs for one clock, then compare every output against the model.
  task automatic step(input logic r, input logic e, input logic x);
    rst_n = r; en = e; sig = x;
    @(posedge clk);
    #1;
    model_edge(r, e, x);
    check_eq("meas_valid", {31'd0, meas_valid}, {31'd0, exp_mv});
    check_eq("ton_cyc", 32'(ton_cyc), exp_ton);
    check_eq("toff_cyc", 32'(toff_cyc), exp_toff);
    check_eq("period_cyc", 32'(period_cyc), exp_per);
    check_eq("stuck_high", {31'd0, stuck_high}, {31'd0, exp_sh});
    check_eq("stuck_low", {31'd0, stuck_low}, {31'd0, exp_sl});
  endtask

  task automatic seg(input int hi, input int lo);
    repeat (hi) step(1'b1, 1'b1, 1'b1);
    repeat (lo) step(1'b1, 1'b1, 1'b0);
  endtask

  int hi, lo, k;

  initial begin
    for (int i = 0; i <= SYNC_STAGES; i++) hist[i] = 1'b0;
    rst_n = 1'b0; en = 1'b0; sig = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check_eq("reset_ton", 32'(ton_cyc), 0);
    check_eq("reset_valid", {31'd0, meas_valid}, 0);
    repeat (2) step(1'b1, 1'b1, 1'b0);

    // 4 high / 6 low
    repeat (6) seg(4, 6);
    check_eq("dir1_ton", 32'(ton_cyc), 4);
    check_eq("dir1_toff", 32'(toff_cyc), 6);
    check_eq("dir1_period", 32'(period_cyc), 10);

    // 1/1 toggle
    repeat (10) seg(1, 1);
    check_eq("dir2_ton", 32'(ton_cyc), 1);
    check_eq("dir2_period", 32'(period_cyc), 2);

    // duty change 3/7 then 7/3
    repeat (3) seg(3, 7);
    check_eq("dir3_ton_a", 32'(ton_cyc), 3);
    repeat (3) seg(7, 3);
    check_eq("dir3_ton_b", 32'(ton_cyc), 7);
    check_eq("dir3_toff_b", 32'(toff_cyc), 3);

    // stuck high, then 2/2 clears it
    repeat (20) step(1'b1, 1'b1, 1'b1);
    check_eq("dir4_stuck_high", {31'd0, stuck_high}, 1);
    check_eq("dir4_ton_held", 32'(ton_cyc), 7);
    repeat (6) seg(2, 2);
    check_eq("dir4_stuck_clr", {31'd0, stuck_high}, 0);
    check_eq("dir4_ton", 32'(ton_cyc), 2);

    // reset for one cycle mid-high
    seg(4, 6);
    seg(4, 6);
    repeat (2) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check_eq("dir5_ton_clr", 32'(ton_cyc), 0);
    check_eq("dir5_period_clr", 32'(period_cyc), 0);
    repeat (2) step(1'b1, 1'b1, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0);
    repeat (3) seg(4, 6);

    // en dropped mid-low for 5 cycles
    seg(4, 6);
    repeat (4) step(1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0);
    repeat (3) seg(4, 6);
    check_eq("dir6_ton", 32'(ton_cyc), 4);
    check_eq("dir6_toff", 32'(toff_cyc), 6);

    // random pulse trains with occasional enable drops and resets
    for (int n = 0; n < 200; n++) begin
      hi = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 8));
      lo = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 8));
      k  = int'($urandom_range(0, 29));
      if (k == 0) begin
        repeat ($urandom_range(1, 6)) step(1'b1, 1'b0, 1'b1);
      end else if (k == 1) begin
        step(1'b0, 1'b1, 1'b1);
      end
      seg(hi, lo);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
